// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART transmit path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} tx_state_t;
  localparam int UART_DATA_W = 8;
  localparam int DEFAULT_BAUD_DIV = 868;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider; restarts from zero whenever clr is high.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == W'(BAUD_DIV - 1);
  assign cnt_d = (clr || bit_end) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and shifts them out as UART frames.
// Parity bit support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   empty,
  input  logic [UART_DATA_W-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_en,
  input  logic                   parity_odd,
`endif
  input  logic                   two_stop,
  output logic                   pop,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);
  tx_state_t state_q, state_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic stop_q, stop_d, two_q, two_d;
  logic tx_q, tx_d, pop_q, busy_q, busy_d, done_q, done_d;
  logic bit_end, fetch;
`ifdef UART_TX_PARITY_EN
  logic pen_q, pen_d, par_q, par_d;
`endif
  assign fetch = en && !empty;
  // The divider restarts on every state change so each state gets whole bit periods.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .bit_end (bit_end)
  );
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    two_d   = two_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_d   = pen_q;
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  state_d = fetch ? POP : IDLE;
      POP:   state_d = LOAD;
      LOAD: begin
        sh_d    = din;
        two_d   = two_stop;
        stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        pen_d   = parity_en;
        par_d   = ^din ^ parity_odd;
`endif
        state_d = START;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = pen_q ? PARITY : STOP;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = bit_end ? STOP : PARITY;
`endif
      STOP: if (bit_end) begin
        if (two_q && !stop_q) stop_d = 1'b1;
        else begin
          stop_d  = 1'b0;
          done_d  = 1'b1;
          state_d = fetch ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA)  ? sh_d[0] :
`ifdef UART_TX_PARITY_EN
           (state_d == PARITY) ? par_d :
`endif
           1'b1;
    busy_d = (state_d != IDLE) || done_d;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      two_q   <= 1'b0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      two_q   <= two_d;
      tx_q    <= tx_d;
      pop_q   <= state_d == POP;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      pen_q   <= pen_d;
      par_q   <= par_d;
`endif
    end
  assign tx   = tx_q;
  assign pop  = pop_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed scoreboard bench; parity scenarios run when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;
  localparam int DIV = 4;
  typedef struct {
    logic [7:0] d;
    logic pen, odd, two;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic pop, tx, busy, done;
  int tests = 0, fails = 0, cyc = 0, pop_cnt = 0;
  logic [7:0] fifo[$];
  exp_t exp_q[$];
  uart_tx_serializer #(.BAUD_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .empty      (empty),
    .din        (din),
`ifdef UART_TX_PARITY_EN
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
`endif
    .two_stop   (two_stop),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // FIFO model: read data appears the cycle after pop, empty follows pushes by one clock.
  always @(posedge clk) begin
    if (pop) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo.size() != 0) din <= fifo.pop_front();
    end
    empty <= (fifo.size() == 0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic [7:0] b);
    exp_t e;
    e.d = b;
`ifdef UART_TX_PARITY_EN
    e.pen = parity_en;
`else
    e.pen = 1'b0;
`endif
    e.odd = parity_odd;
    e.two = two_stop;
    fifo.push_back(b);
    exp_q.push_back(e);
  endtask
  // Waits for a start bit, then checks every clock of the frame against the next scoreboard entry.
  task automatic recv(input int drop_bit, output int start_cyc);
    int n, nb, bad;
    exp_t e;
    logic [11:0] lv;
    n = 0;
    start_cyc = -1;
    while (tx !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("start_bit_seen", {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) return;
    start_cyc = cyc;
    chk("scoreboard_empty", {31'd0, exp_q.size() == 0}, 32'd0);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    lv = '1;
    lv[0] = 1'b0;
    lv[8:1] = e.d;
    if (e.pen) lv[9] = ^e.d ^ e.odd;
    nb = 10 + int'(e.pen) + int'(e.two);
    for (int i = 0; i < nb; i++) begin
      bad = 0;
      for (int j = 0; j < DIV; j++) begin
        if (i == drop_bit && j == 0) en = 1'b0;
        if (tx !== lv[i]) bad++;
        if (busy !== 1'b1) bad++;
        if (done !== 1'b0) bad++;
        @(negedge clk);
      end
      chk($sformatf("frame_%02h_bit%0d_errors", e.d, i), bad, 0);
    end
    chk($sformatf("frame_%02h_done", e.d), {31'd0, done}, 32'd1);
  endtask
  initial begin
    int s1, s2, s3, p0, c, bad, n;
    exp_t junk;
    rst = 1'b0;
    en = 1'b1;
    push(8'hA5);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset_c%0d_tx", i), {31'd0, tx}, 32'd1);
      chk($sformatf("reset_c%0d_pop", i), {31'd0, pop}, 32'd0);
      chk($sformatf("reset_c%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("reset_c%0d_done", i), {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    recv(-1, s1);
    chk("single_pop_count", pop_cnt, 1);
    repeat (3) @(negedge clk);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);
`ifdef UART_TX_PARITY_EN
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'h07);
    recv(-1, s1);
    parity_odd = 1'b1;
    push(8'h07);
    recv(-1, s1);
    two_stop = 1'b1;
    push(8'h07);
    recv(-1, s1);
    parity_en = 1'b0;
    parity_odd = 1'b0;
`endif
    two_stop = 1'b1;
    push(8'h3C);
    recv(-1, s1);
    two_stop = 1'b0;
    p0 = pop_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    recv(-1, s1);
    recv(-1, s2);
    recv(-1, s3);
    chk("b2b_gap_1_2", s2 - s1, 10 * DIV + 2);
    chk("b2b_gap_2_3", s3 - s2, 10 * DIV + 2);
    chk("b2b_pop_count", pop_cnt - p0, 3);
    repeat (3) @(negedge clk);
    p0 = pop_cnt;
    push(8'h11);
    push(8'h22);
    recv(2, s1);
    repeat (12) @(negedge clk);
    chk("endrop_no_pop", pop_cnt - p0, 1);
    chk("endrop_idle_busy", {31'd0, busy}, 32'd0);
    c = cyc;
    en = 1'b1;
    recv(-1, s2);
    chk("endrop_restart_latency", s2 - c, 3);
    chk("endrop_pop_count", pop_cnt - p0, 2);
    repeat (3) @(negedge clk);
    push(8'h5A);
    n = 0;
    while (tx !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_frame_started", {31'd0, tx}, 32'd0);
    repeat (2 * DIV) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_tx", {31'd0, tx}, 32'd1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_pop", {31'd0, pop}, 32'd0);
    if (exp_q.size() != 0) junk = exp_q.pop_front();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    p0 = pop_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
      if (tx !== 1'b1) bad++;
    end
    chk("postreset_idle_errors", bad, 0);
    chk("postreset_no_pop", pop_cnt - p0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
